// File: rtl/line_clear.sv
// line_clear: post-landing row-collapse engine for the playfield.
//
// Takes the background occupancy map on a start pulse, removes every
// completely filled row (shifting the rows above it down by one), and
// returns the collapsed map with the per-pass line count and a running
// score.
//
// Ports:
//   Clk           - system clock, rising edge
//   Reset_n       - synchronous active-low reset
//   start         - one-cycle request, sampled only in IDLE
//   state_in      - occupancy map, cell (r,c) is bit r*COLS+c, row 0 on top
//   busy          - high from the accept edge until the edge leaving DONE
//   done          - one-cycle completion pulse
//   write_en      - load strobe for savedblocks, coincident with done
//   state_out     - collapsed map, held between passes
//   lines_cleared - rows removed in the last pass
//   score         - saturating running total since reset
//
// Configuration macro: LINE_CLEAR_SCORE_EN
//   defined   - score adds 0/40/100/300/1200 points per pass
//   undefined - score adds the plain number of lines cleared
module line_clear #(
    parameter int COLS = 10,
    parameter int ROWS = 24
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    input  logic [ROWS*COLS-1:0]   state_in,
    output logic                   busy,
    output logic                   done,
    output logic                   write_en,
    output logic [ROWS*COLS-1:0]   state_out,
    output logic [4:0]             lines_cleared,
    output logic [15:0]            score
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [ROWS*COLS-1:0]   r_work;
    logic [4:0]             r_ptr;
    logic [4:0]             r_cnt;

    logic [COLS-1:0]        w_row;
    logic                   w_row_full;
    logic [ROWS*COLS-1:0]   w_shifted;
    logic [15:0]            w_points;
    logic [16:0]            w_score_sum;
    logic [15:0]            w_score_next;

    assign w_row      = r_work[32'(r_ptr)*COLS +: COLS];
    assign w_row_full = (w_row == '1);

    // Rows 1..ptr take the row above them, row 0 is cleared, rows below
    // ptr keep their contents.
    always_comb begin
        w_shifted = r_work;
        for (int unsigned r = 1; r < ROWS; r++) begin
            if (r <= 32'(r_ptr)) begin
                w_shifted[r*COLS +: COLS] = r_work[(r-1)*COLS +: COLS];
            end
        end
        w_shifted[0 +: COLS] = '0;
    end

    // DONE is only entered from SCAN, which never updates r_cnt, so
    // r_cnt is already the final count on the edge entering DONE.
    always_comb begin
        w_points = '0;
`ifdef LINE_CLEAR_SCORE_EN
        case (r_cnt)
            5'd0:    w_points = 16'd0;
            5'd1:    w_points = 16'd40;
            5'd2:    w_points = 16'd100;
            5'd3:    w_points = 16'd300;
            default: w_points = 16'd1200;
        endcase
`else
        w_points = {11'b0, r_cnt};
`endif
    end

    assign w_score_sum  = {1'b0, score} + {1'b0, w_points};
    assign w_score_next = w_score_sum[16] ? '1 : w_score_sum[15:0];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= S_IDLE;
            r_work        <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            write_en      <= 1'b0;
            state_out     <= '0;
            lines_cleared <= '0;
            score         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= state_in;
                        r_ptr   <= 5'(ROWS - 1);
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_row_full) begin
                        r_state <= S_SHIFT;
                    end else if (r_ptr == '0) begin
                        state_out     <= r_work;
                        lines_cleared <= r_cnt;
                        score         <= w_score_next;
                        done          <= 1'b1;
                        write_en      <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_ptr <= r_ptr - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // ptr is kept so the row dropped into place is re-tested
                    r_work  <= w_shifted;
                    r_cnt   <= r_cnt + 5'd1;
                    r_state <= S_SCAN;
                end
                S_DONE: begin
                    done     <= 1'b0;
                    write_en <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
module tb_line_clear;

    localparam int COLS = 10;
    localparam int ROWS = 24;
    localparam int W    = ROWS * COLS;

    logic           Clk;
    logic           Reset_n;
    logic           start;
    logic [W-1:0]   state_in;
    logic           busy;
    logic           done;
    logic           write_en;
    logic [W-1:0]   state_out;
    logic [4:0]     lines_cleared;
    logic [15:0]    score;

    line_clear #(.COLS(COLS), .ROWS(ROWS)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .start         (start),
        .state_in      (state_in),
        .busy          (busy),
        .done          (done),
        .write_en      (write_en),
        .state_out     (state_out),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned    exp_cyc;
        logic [W-1:0]   exp_map;
        logic [4:0]     exp_lines;
        logic [15:0]    exp_score;
    } sb_item_t;

    sb_item_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int unsigned model_score = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int unsigned points(input int unsigned lines);
`ifdef LINE_CLEAR_SCORE_EN
        case (lines)
            0:       return 0;
            1:       return 40;
            2:       return 100;
            3:       return 300;
            default: return 1200;
        endcase
`else
        return lines;
`endif
    endfunction

    function automatic logic [W-1:0] row_set(input logic [W-1:0] m, input int r,
                                             input logic [COLS-1:0] v);
        logic [W-1:0] t;
        t = m;
        t[r*COLS +: COLS] = v;
        return t;
    endfunction

    // Monitor: pops the expected result whenever the DUT signals completion.
    always @(negedge Clk) begin
        if (done || write_en) begin
            chk("write_en_eq_done", W'(write_en), W'(done));
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", W'(1), W'(0));
            end else begin
                sb_item_t e;
                e = sb.pop_front();
                chk("done_cycle", W'(cyc), W'(e.exp_cyc));
                chk("state_out", state_out, e.exp_map);
                chk("lines_cleared", W'(lines_cleared), W'(e.exp_lines));
                chk("score", W'(score), W'(e.exp_score));
                chk("busy_at_done", W'(busy), W'(1));
            end
        end
    end

    // Issue one pass; the expected result is queued right after the accept edge.
    task automatic run_pass(input logic [W-1:0] map, input logic [W-1:0] exp_map,
                            input int f);
        sb_item_t e;
        @(negedge Clk);
        start    = 1'b1;
        state_in = map;
        @(posedge Clk);
        #1;
        start = 1'b0;
        model_score = model_score + points(f);
        if (model_score > 65535) model_score = 65535;
        e.exp_cyc   = cyc + ROWS + 2 * f;
        e.exp_map   = exp_map;
        e.exp_lines = 5'(f);
        e.exp_score = 16'(model_score);
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk(nm, W'(sb.size()), W'(0));
        sb.delete();
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [W-1:0] m_single, e_single, m_tetris, e_tetris, m_split, e_split;
    int unsigned acc;

    initial begin
        m_single = row_set(row_set('0, 23, 10'h3FF), 22, 10'h155);
        e_single = row_set('0, 23, 10'h155);

        m_tetris = '0;
        for (int r = 20; r < 24; r++) m_tetris = row_set(m_tetris, r, 10'h3FF);
        m_tetris = row_set(m_tetris, 19, 10'h001);
        e_tetris = row_set('0, 23, 10'h001);

        m_split = row_set(row_set(row_set('0, 21, 10'h3FF), 23, 10'h3FF), 22, 10'h201);
        e_split = row_set('0, 23, 10'h201);

        Reset_n  = 1'b0;
        start    = 1'b0;
        state_in = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_write_en", W'(write_en), W'(0));
        chk("rst_state_out", state_out, '0);
        chk("rst_lines", W'(lines_cleared), W'(0));
        chk("rst_score", W'(score), W'(0));
        Reset_n = 1'b1;

        run_pass('0, '0, 0);
        wait_drain("empty_drain");

        run_pass(m_single, e_single, 1);
        wait_drain("single_drain");

        run_pass(m_tetris, e_tetris, 4);
        wait_drain("tetris_drain");

        run_pass(m_split, e_split, 2);
        wait_drain("split_drain");

        // start re-pulsed at edge 5 with a different map must be ignored
        run_pass(m_single, e_single, 1);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        start    = 1'b1;
        state_in = '1;
        @(negedge Clk);
        start    = 1'b0;
        state_in = '0;
        wait_drain("ignore_drain");
        repeat (30) @(negedge Clk);

        // reset at edge 10 of a pass aborts it without a write_en
        @(negedge Clk);
        start    = 1'b1;
        state_in = m_tetris;
        @(posedge Clk);
        #1;
        acc   = cyc;
        start = 1'b0;
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        chk("busy_before_abort", W'(busy), W'(1));
        Reset_n = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("abort_edge", W'(cyc), W'(acc + 10));
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_write_en", W'(write_en), W'(0));
        chk("abort_score", W'(score), W'(0));
        chk("abort_state_out", state_out, '0);
        Reset_n = 1'b1;
        model_score = 0;
        repeat (40) @(negedge Clk);

        run_pass(m_single, e_single, 1);
        wait_drain("post_abort_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
